// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned 4x4 matrix keypad front end.
// Drives one row low per slot, reads the active-low columns back through a
// two-flop synchronizer, debounces the full 16-key frame, decodes single
// key presses into a hex code and shifts accepted codes into a 16-bit
// number register for the display driver.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [3:0]  col_sense,
    output logic [3:0]  row_drive,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] number
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam int unsigned MW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        BLOCKED
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [3:0]      col_meta;
    logic [3:0]      col_sync;

    logic [CW-1:0]   slot_cnt;
    logic [1:0]      row_idx;
    logic [1:0]      row_next;
    logic            slot_last;
    logic            frame_end;

    logic [11:0]     snap_lo;
    logic [15:0]     frame_full;
    logic [15:0]     prev_snap;
    logic [15:0]     stable;
    logic [MW-1:0]   match_cnt;
    logic [MW-1:0]   match_next;

    logic [4:0]      hot_count;
    logic [3:0]      hot_index;
    logic            single_key;

    logic [3:0]      key_code_q;
    logic [15:0]     number_next;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign frame_end  = slot_last && (row_idx == 2'd3);
    assign row_next   = row_idx + 2'd1;
    // Row 3 is the slot being sampled at frame end, so it is taken live
    // from the synchronizer rather than from the stored rows.
    assign frame_full = {~col_sync, snap_lo};

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_sense;
            col_sync <= col_meta;
        end
    end

    // Slot timing and row strobe generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt  <= '0;
            row_idx   <= 2'd0;
            row_drive <= 4'b1110;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            row_idx   <= row_next;
            row_drive <= ~(4'b0001 << row_next);
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // Capture rows 0..2 of the current frame at the end of their slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_lo <= '0;
        end else if (slot_last) begin
            case (row_idx)
                2'd0:    snap_lo[3:0]  <= ~col_sync;
                2'd1:    snap_lo[7:4]  <= ~col_sync;
                2'd2:    snap_lo[11:8] <= ~col_sync;
                default: snap_lo       <= snap_lo;
            endcase
        end
    end

    // Count consecutive identical frames, saturating at the debounce limit.
    always_comb begin
        match_next = '0;
        if (frame_full == prev_snap) begin
            match_next = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
        end
    end

    // Frame-end debounce: remember the frame, promote it once it has held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_snap <= '0;
            match_cnt <= '0;
            stable    <= '0;
        end else if (frame_end) begin
            prev_snap <= frame_full;
            match_cnt <= match_next;
            if (match_next == MATCH_MAX) begin
                stable <= frame_full;
            end
        end
    end

    // Population count and position of the pressed keys in the stable frame.
    always_comb begin
        hot_count = '0;
        hot_index = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (stable[i]) begin
                hot_count = hot_count + 5'd1;
                hot_index = 4'(i);
            end
        end
        single_key = (hot_count == 5'd1);
    end

    // Press FSM: report a lone key leaving the released state, then wait
    // for full release before another key can be reported.
    always_comb begin
        state_next = state;
        key_valid  = 1'b0;
        key_code   = key_code_q;
        case (state)
            IDLE: begin
                if (single_key) begin
                    key_valid  = 1'b1;
                    key_code   = hot_index;
                    state_next = PRESSED;
                end else if (stable != '0) begin
                    state_next = BLOCKED;
                end
            end
            PRESSED, BLOCKED: begin
                if (stable == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear takes effect before a same-cycle shift-in.
    always_comb begin
        number_next = clear ? '0 : number;
        if (key_valid) begin
            number_next = {number_next[11:0], hot_index};
        end
    end

    // FSM state, held code, number register and key_down flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            key_code_q <= '0;
            number     <= '0;
            key_down   <= 1'b0;
        end else begin
            state      <= state_next;
            key_code_q <= key_code;
            number     <= number_next;
            key_down   <= (stable != '0);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a frame-level
// behavioural model of the keypad, debounce and key-event rules.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 2;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [3:0]  col_sense;
    logic [3:0]  row_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] number;

    logic [15:0] keys;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .col_sense (col_sense),
        .row_drive (row_drive),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .number    (number)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive keypad: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        col_sense = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !row_drive[r]) col_sense[c] = 1'b0;
            end
        end
    end

    // Behavioural model state
    int          m_cyc = 0;
    logic [15:0] m_stable = '0;
    logic [15:0] hist[$];
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_code = '0;
    logic [15:0] exp_num = '0;
    logic        exp_down = 1'b0;

    function automatic logic [3:0] key_index(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Model: a frame is the key set held during it; a frame is accepted when
    // it equals the previous DEBOUNCE-1 frames; an event is a lone key
    // appearing in the accepted state directly after all-released.
    always @(posedge clk or negedge rst) begin
        logic [15:0] nn;
        logic        same;
        if (!rst) begin
            m_cyc     = 0;
            m_stable  = '0;
            hist.delete();
            hist.push_back(16'h0000);
            exp_valid = 1'b0;
            exp_code  = '0;
            exp_num   = '0;
            exp_down  = 1'b0;
        end else begin
            exp_down = (m_stable != 16'h0000);
            nn = clear ? 16'h0000 : exp_num;
            if (exp_valid) nn = {nn[11:0], exp_code};
            exp_num   = nn;
            exp_valid = 1'b0;
            m_cyc++;
            if (m_cyc % FRAME == 0) begin
                hist.push_back(keys);
                same = (hist.size() >= DEBOUNCE);
                for (int i = 1; i < DEBOUNCE; i++) begin
                    if (same && hist[hist.size() - 1 - i] != keys) same = 1'b0;
                end
                if (same) begin
                    if (m_stable == 16'h0000 && $countones(keys) == 1) begin
                        exp_valid = 1'b1;
                        exp_code  = key_index(keys);
                    end
                    m_stable = keys;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [3:0] exp_row;
        exp_row = ~(4'b0001 << ((m_cyc / SCAN_DIV) % 4));
        check("row_drive", 32'(row_drive), 32'(exp_row));
        check("key_valid", 32'(key_valid), 32'(exp_valid));
        check("key_code",  32'(key_code),  32'(exp_code));
        check("key_down",  32'(key_down),  32'(exp_down));
        check("number",    32'(number),    32'(exp_num));
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    // Return at the negedge following a frame-end sample.
    task automatic next_frame();
        @(negedge clk);
        while (m_cyc == 0 || (m_cyc % FRAME) != 0) @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) next_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic got;
        rst   = 1'b0;
        clear = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Idle scanning
        frames(3);
        #1;
        check("t1_pulses", 32'(pulses), 32'd0);
        check("t1_number", 32'(number), 32'h0000);

        // Single key held for five frames
        keys = 16'h0040;
        p0 = pulses;
        frames(5);
        #1;
        check("t2_pulses", 32'(pulses - p0), 32'd1);
        check("t2_code",   32'(key_code), 32'h6);
        check("t2_number", 32'(number), 32'h0006);
        check("t2_down",   32'(key_down), 32'd1);
        keys = '0;
        frames(3);
        #1;
        check("t2_up", 32'(key_down), 32'd0);

        // Keys 1..4 in sequence
        p0 = pulses;
        for (int k = 1; k <= 4; k++) begin
            keys = 16'(1 << k);
            frames(4);
            keys = '0;
            frames(4);
        end
        #1;
        check("t3_pulses", 32'(pulses - p0), 32'd4);
        check("t3_number", 32'(number), 32'h1234);

        // One-frame glitch on key 0
        p0 = pulses;
        keys = 16'h0001;
        frames(1);
        keys = '0;
        frames(3);
        #1;
        check("t4_pulses", 32'(pulses - p0), 32'd0);
        check("t4_number", 32'(number), 32'h1234);

        // Two keys together, then a lone key, then a roll-over
        p0 = pulses;
        keys = 16'h0021;
        frames(4);
        keys = '0;
        frames(4);
        #1;
        check("t5_dual", 32'(pulses - p0), 32'd0);
        keys = 16'h0001;
        frames(4);
        keys = '0;
        frames(4);
        #1;
        check("t5_single", 32'(pulses - p0), 32'd1);
        check("t5_code0",  32'(key_code), 32'h0);
        check("t5_num0",   32'(number), 32'h2340);
        p0 = pulses;
        keys = 16'h0008;
        frames(3);
        keys = 16'h0088;
        frames(3);
        keys = 16'h0080;
        frames(3);
        keys = '0;
        frames(4);
        #1;
        check("t5_roll",  32'(pulses - p0), 32'd1);
        check("t5_code3", 32'(key_code), 32'h3);
        check("t5_num3",  32'(number), 32'h3403);

        // Clear coinciding with the key event
        keys = 16'h0200;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) got = 1'b1;
        end
        check("t6_event_seen", 32'(got), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("t6_clear_num", 32'(number), 32'h0009);

        // Reset mid-frame with key 9 held
        frames(1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t6_rst_num",  32'(number), 32'h0000);
        check("t6_rst_down", 32'(key_down), 32'd0);
        check("t6_rst_row",  32'(row_drive), 32'hE);
        check("t6_rst_code", 32'(key_code), 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        p0 = pulses;
        frames(2);
        #1;
        check("t6_again",      32'(pulses - p0), 32'd1);
        check("t6_again_code", 32'(key_code), 32'h9);
        frames(1);
        #1;
        check("t6_again_num", 32'(number), 32'h0009);
        keys = '0;
        frames(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
